// File: rtl/conv_sched.sv
// Raster-order window sequencer for the convolution datapath: issues one window per
// unstalled cycle for every kernel and tracks results through the fixed-latency convolve pipe.
module conv_sched #(
    parameter int KERNEL_SIZE = 3,
    parameter int IMGROW      = 32,
    parameter int IMGCOL      = 32,
    parameter int NUM_KERNELS = 4,
    parameter int PIPE_LAT    = 3,
    localparam int RW    = (IMGROW > 1) ? $clog2(IMGROW) : 1,
    localparam int CW    = (IMGCOL > 1) ? $clog2(IMGCOL) : 1,
    localparam int KW    = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
    localparam int TOTAL = NUM_KERNELS * IMGROW * IMGCOL,
    localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1,
    localparam int NT    = KERNEL_SIZE * KERNEL_SIZE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
    output logic          busy,
    output logic          done,
    output logic          win_valid,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic [KW-1:0] ker_sel,
    output logic [NT-1:0] pad_mask,
    output logic          out_valid,
    output logic [AW-1:0] out_addr
);

    localparam int PAD = (KERNEL_SIZE - 1) / 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] ker_q, ker_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          win_valid_q, win_valid_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic [KW-1:0] ker_sel_q, ker_sel_d;
    logic [NT-1:0] pad_mask_q, pad_mask_d;
    logic [PIPE_LAT-1:0] vld_q, vld_d;
    logic [AW-1:0] addr_q, addr_d;

    logic          res_valid;
    logic          last_win;
    logic          col_last;
    logic          row_last;
    logic          ker_last;
    logic [NT-1:0] mask_c;

    assign res_valid = vld_q[PIPE_LAT-1];
    assign col_last  = (col_q == CW'(IMGCOL - 1));
    assign row_last  = (row_q == RW'(IMGROW - 1));
    assign ker_last  = (ker_q == KW'(NUM_KERNELS - 1));
    assign last_win  = col_last && row_last && ker_last;

    // Taps are compared as 32-bit signed ints so the "-PAD" side and the ">= size" side
    // both stay exact regardless of counter width.
    always_comb begin
        mask_c = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            for (int j = 0; j < KERNEL_SIZE; j++) begin
                mask_c[i*KERNEL_SIZE+j] = (int'(row_q) + i - PAD < 0)
                                       || (int'(row_q) + i - PAD >= IMGROW)
                                       || (int'(col_q) + j - PAD < 0)
                                       || (int'(col_q) + j - PAD >= IMGCOL);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        ker_d       = ker_q;
        row_d       = row_q;
        col_d       = col_q;
        win_valid_d = 1'b0;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        ker_sel_d   = ker_sel_q;
        pad_mask_d  = pad_mask_q;
        addr_d      = res_valid ? addr_q + AW'(1) : addr_q;

        vld_d[0] = win_valid_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    ker_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    win_valid_d = 1'b1;
                    win_row_d   = row_q;
                    win_col_d   = col_q;
                    ker_sel_d   = ker_q;
                    pad_mask_d  = mask_c;
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            row_d = '0;
                            ker_d = ker_last ? '0 : ker_q + KW'(1);
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (last_win) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (res_valid && addr_q == AW'(TOTAL - 1)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ker_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            ker_sel_q   <= '0;
            pad_mask_q  <= '0;
            vld_q       <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            ker_q       <= ker_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            ker_sel_q   <= ker_sel_d;
            pad_mask_q  <= pad_mask_d;
            vld_q       <= vld_d;
            addr_q      <= addr_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign ker_sel   = ker_sel_q;
    assign pad_mask  = pad_mask_q;
    assign out_valid = res_valid;
    assign out_addr  = addr_q;

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched: a 4x4/2-kernel/lat-3 instance and a 3x3/1-kernel/lat-1
// instance, with a window model and an out_addr/arrival-cycle scoreboard.
module tb_conv_sched;

    localparam int A_R = 4, A_C = 4, A_K = 2, A_L = 3, A_TOT = A_R * A_C * A_K;
    localparam int B_R = 3, B_C = 3, B_L = 1, B_TOT = B_R * B_C;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       a_start = 1'b0, a_stall = 1'b0;
    logic       a_busy, a_done, a_win_valid, a_out_valid;
    logic [1:0] a_win_row, a_win_col;
    logic [0:0] a_ker_sel;
    logic [8:0] a_pad_mask;
    logic [4:0] a_out_addr;

    logic       b_start = 1'b0, b_stall = 1'b0;
    logic       b_busy, b_done, b_win_valid, b_out_valid;
    logic [1:0] b_win_row, b_win_col;
    logic [0:0] b_ker_sel;
    logic [8:0] b_pad_mask;
    logic [3:0] b_out_addr;

    conv_sched #(.KERNEL_SIZE(3), .IMGROW(A_R), .IMGCOL(A_C), .NUM_KERNELS(A_K), .PIPE_LAT(A_L)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .stall(a_stall), .busy(a_busy), .done(a_done),
        .win_valid(a_win_valid), .win_row(a_win_row), .win_col(a_win_col), .ker_sel(a_ker_sel),
        .pad_mask(a_pad_mask), .out_valid(a_out_valid), .out_addr(a_out_addr));

    conv_sched #(.KERNEL_SIZE(3), .IMGROW(B_R), .IMGCOL(B_C), .NUM_KERNELS(1), .PIPE_LAT(B_L)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .stall(b_stall), .busy(b_busy), .done(b_done),
        .win_valid(b_win_valid), .win_row(b_win_row), .win_col(b_win_col), .ker_sel(b_ker_sel),
        .pad_mask(b_pad_mask), .out_valid(b_out_valid), .out_addr(b_out_addr));

    typedef struct {
        int addr;
        int cyc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t a_q[$];
    exp_t b_q[$];
    int   mk, mr, mc, a_win_cnt, a_out_cnt, a_done_cnt, a_done_cyc, a_first_cyc;
    int   bmr, bmc, b_win_cnt, b_out_cnt, b_done_cnt, b_done_cyc, b_first_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model_mask(input int r, input int c, input int nr, input int nc);
        logic [8:0] m;
        m = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                m[i*3+j] = (r - 1 + i < 0) || (r - 1 + i >= nr) || (c - 1 + j < 0) || (c - 1 + j >= nc);
        return m;
    endfunction

    // One clock: advance to the edge, sample 1 ns later, run both monitors.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (a_win_valid) begin
            check("a_win_in_frame", a_win_cnt < A_TOT, 1);
            check("a_win_row", a_win_row, mr);
            check("a_win_col", a_win_col, mc);
            check("a_ker_sel", a_ker_sel, mk);
            check("a_pad_mask", a_pad_mask, model_mask(mr, mc, A_R, A_C));
            if (mk == 0 && mr == 0 && mc == 0) check("a_pad_00", a_pad_mask, 9'h04F);
            if (mk == 0 && mr == 3 && mc == 3) check("a_pad_33", a_pad_mask, 9'h1E4);
            if (mk == 0 && mr == 1 && mc == 1) check("a_pad_11", a_pad_mask, 9'h000);
            a_q.push_back('{addr: mk * A_R * A_C + mr * A_C + mc, cyc: cyc + A_L});
            a_win_cnt++;
            if (a_win_cnt == 1) a_first_cyc = cyc;
            mc++;
            if (mc == A_C) begin mc = 0; mr++; end
            if (mr == A_R) begin mr = 0; mk++; end
        end
        if (a_out_valid) begin
            check("a_out_pending", a_q.size() > 0, 1);
            if (a_q.size() > 0) begin
                e = a_q.pop_front();
                check("a_out_addr", a_out_addr, e.addr);
                check("a_out_latency", cyc, e.cyc);
            end
            a_out_cnt++;
        end
        if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end

        if (b_win_valid) begin
            check("b_win_in_frame", b_win_cnt < B_TOT, 1);
            check("b_win_row", b_win_row, bmr);
            check("b_win_col", b_win_col, bmc);
            check("b_ker_sel", b_ker_sel, 0);
            check("b_pad_mask", b_pad_mask, model_mask(bmr, bmc, B_R, B_C));
            b_q.push_back('{addr: bmr * B_C + bmc, cyc: cyc + B_L});
            b_win_cnt++;
            if (b_win_cnt == 1) b_first_cyc = cyc;
            bmc++;
            if (bmc == B_C) begin bmc = 0; bmr++; end
        end
        if (b_out_valid) begin
            check("b_out_pending", b_q.size() > 0, 1);
            if (b_q.size() > 0) begin
                e = b_q.pop_front();
                check("b_out_addr", b_out_addr, e.addr);
                check("b_out_latency", cyc, e.cyc);
            end
            b_out_cnt++;
        end
        if (b_done) begin b_done_cnt++; b_done_cyc = cyc; end
    endtask

    // Clear the A model and pulse start so that it is sampled at edge 0.
    task automatic begin_a();
        mk = 0; mr = 0; mc = 0;
        a_win_cnt = 0; a_out_cnt = 0; a_done_cnt = 0; a_done_cyc = -1; a_first_cyc = -1;
        a_q.delete();
        cyc = -1;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("a_busy_after_start", a_busy, 1);
    endtask

    task automatic wait_done_a(input bit poke_start);
        int n;
        n = 0;
        while (a_done_cnt == 0 && n < 400) begin tick(); n++; end
        check("a_done_seen", a_done_cnt, 1);
        if (a_done_cnt != 0) begin
            check("a_busy_in_done", a_busy, 1);
            if (poke_start) a_start = 1'b1;
            tick();
            a_start = 1'b0;
            check("a_busy_low_after_done", a_busy, 0);
            check("a_done_one_cycle", a_done, 0);
        end
    endtask

    task automatic end_frame_a(input int exp_done_cyc);
        repeat (3) tick();
        check("a_done_cycle", a_done_cyc, exp_done_cyc);
        check("a_done_count", a_done_cnt, 1);
        check("a_first_win_cycle", a_first_cyc, 1);
        check("a_win_count", a_win_cnt, A_TOT);
        check("a_out_count", a_out_cnt, A_TOT);
        check("a_queue_empty", a_q.size(), 0);
        check("a_idle_busy", a_busy, 0);
        check("a_idle_win_valid", a_win_valid, 0);
    endtask

    initial begin
        // Reset state of both instances.
        #3;
        check("rst_a_busy", a_busy, 0);
        check("rst_a_done", a_done, 0);
        check("rst_a_win_valid", a_win_valid, 0);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_addr", a_out_addr, 0);
        check("rst_a_pad_mask", a_pad_mask, 0);
        check("rst_b_busy", b_busy, 0);
        check("rst_b_out_addr", b_out_addr, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // Plain frame: windows at edges 1..32, results at 4..35, done at 36.
        begin_a();
        wait_done_a(1'b0);
        end_frame_a(36);

        // Stall for 5 cycles in place of the 7th issue; done slips by exactly 5.
        begin_a();
        repeat (6) tick();
        a_stall = 1'b1;
        repeat (5) begin
            tick();
            check("a_stall_no_issue", a_win_valid, 0);
            check("a_stall_hold_row", a_win_row, 1);
            check("a_stall_hold_col", a_win_col, 1);
        end
        a_stall = 1'b0;
        wait_done_a(1'b0);
        end_frame_a(41);

        // start while busy (mid-ISSUE and in DONE) is ignored; a start in IDLE restarts cleanly.
        begin_a();
        repeat (10) tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        wait_done_a(1'b1);
        end_frame_a(36);
        begin_a();
        wait_done_a(1'b0);
        end_frame_a(36);

        // Asynchronous reset during DRAIN clears every output at once and suppresses done.
        begin_a();
        repeat (33) tick();
        check("a_drain_busy", a_busy, 1);
        check("a_drain_out_valid", a_out_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", a_busy, 0);
        check("arst_done", a_done, 0);
        check("arst_win_valid", a_win_valid, 0);
        check("arst_win_row", a_win_row, 0);
        check("arst_win_col", a_win_col, 0);
        check("arst_ker_sel", a_ker_sel, 0);
        check("arst_pad_mask", a_pad_mask, 0);
        check("arst_out_valid", a_out_valid, 0);
        check("arst_out_addr", a_out_addr, 0);
        a_q.delete();
        repeat (3) tick();
        check("arst_no_done", a_done_cnt, 0);
        check("arst_held_idle", a_busy, 0);
        rst = 1'b1;
        tick();
        begin_a();
        wait_done_a(1'b0);
        end_frame_a(36);

        // Single kernel, 3x3 image, one-cycle pipe: 9 windows, 9 results, done at edge 11.
        bmr = 0; bmc = 0;
        b_win_cnt = 0; b_out_cnt = 0; b_done_cnt = 0; b_done_cyc = -1; b_first_cyc = -1;
        b_q.delete();
        cyc = -1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int n = 0; n < 200 && b_done_cnt == 0; n++) tick();
        tick();
        check("b_busy_low_after_done", b_busy, 0);
        repeat (2) tick();
        check("b_done_cycle", b_done_cyc, 11);
        check("b_done_count", b_done_cnt, 1);
        check("b_first_win_cycle", b_first_cyc, 1);
        check("b_win_count", b_win_cnt, B_TOT);
        check("b_out_count", b_out_cnt, B_TOT);
        check("b_queue_empty", b_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
